// File: rtl/vx_index_table.sv
// vx_index_table: slot allocator with lowest-free-first grant, multi-port release and payload RAM.
// acq_addr_o is precomputed from the next-state free mask so a grant never waits on a priority search.
module vx_index_table #(
    parameter int DATAW   = 32,
    parameter int SIZE    = 8,
    parameter int NUM_REL = 2,
    parameter int OUT_REG = 0,
    localparam int ADDRW  = (SIZE > 1) ? $clog2(SIZE) : 1,
    localparam int CNTW   = $clog2(SIZE + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     acq_valid_i,
    input  logic [DATAW-1:0]         acq_data_i,
    output logic                     acq_ready_o,
    output logic [ADDRW-1:0]         acq_addr_o,
    input  logic [ADDRW-1:0]         rd_addr_i,
    output logic [DATAW-1:0]         rd_data_o,
    input  logic [NUM_REL-1:0]       rel_valid_i,
    input  logic [NUM_REL*ADDRW-1:0] rel_addr_i,
    output logic [CNTW-1:0]          count_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     err_rel_o
);
    logic [SIZE-1:0]  free_q, free_d, rel_hit, acq_mask, freed;
    logic [ADDRW-1:0] acq_addr_q, acq_addr_d;
    logic [CNTW-1:0]  count_q, count_d, freed_cnt;
    logic             empty_q, full_q, err_q, err_d, acq_fire;
    logic [DATAW-1:0] mem [SIZE];

    assign acq_fire = acq_valid_i & ~full_q;

    // Duplicate releases collapse into one mask bit, so a slot is freed and counted once.
    always_comb begin
        rel_hit = '0;
        for (int i = 0; i < NUM_REL; i++)
            if (rel_valid_i[i]) rel_hit[rel_addr_i[i*ADDRW +: ADDRW]] = 1'b1;
        acq_mask = acq_fire ? (SIZE'(1) << acq_addr_q) : '0;
        freed = rel_hit & ~free_q;
        freed_cnt = '0;
        for (int i = 0; i < SIZE; i++) freed_cnt = freed_cnt + CNTW'(freed[i]);
        free_d = (free_q | freed) & ~acq_mask;
        count_d = count_q + CNTW'(acq_fire) - freed_cnt;
        err_d = err_q | (|(rel_hit & free_q));
        acq_addr_d = '0;
        for (int i = SIZE - 1; i >= 0; i--) if (free_d[i]) acq_addr_d = ADDRW'(i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            free_q     <= '1;
            acq_addr_q <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            free_q     <= free_d;
            acq_addr_q <= acq_addr_d;
            count_q    <= count_d;
            empty_q    <= count_d == '0;
            full_q     <= count_d == CNTW'(SIZE);
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) if (acq_fire && !reset) mem[acq_addr_q] <= acq_data_i;

    generate
        if (OUT_REG != 0) begin : g_reg
            logic [DATAW-1:0] rd_q;
            always_ff @(posedge clk) rd_q <= reset ? '0 : mem[rd_addr_i];
            assign rd_data_o = rd_q;
        end else begin : g_comb
            assign rd_data_o = mem[rd_addr_i];
        end
    endgenerate

    assign acq_ready_o = ~full_q;
    assign acq_addr_o  = acq_addr_q;
    assign count_o     = count_q;
    assign empty_o     = empty_q;
    assign full_o      = full_q;
    assign err_rel_o   = err_q;
endmodule

// File: doc/vx_index_table.md
VX_INDEX_TABLE -- requirements
Module: VX_index_table

Interface
REQ-001 SHALL have parameter DATAW, default 32: width of payload stored per slot.
REQ-002 SHALL have parameter SIZE, default 8: number of slots; legal range is 2 or more.
REQ-003 SHALL have parameter NUM_REL, default 2: number of independent release ports; legal range is 1 or more.
REQ-004 SHALL have parameter OUT_REG, default 0: 0 = combinational read, 1 = registered read with 1-cycle latency.
REQ-005 SHALL have derived ADDRW = LOG2UP(SIZE) and CNTW = LOG2UP(SIZE+1).
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 acq_valid  input  1  request to allocate a slot.
REQ-009 acq_data  input  DATAW  payload written into the allocated slot.
REQ-010 acq_ready  output  1  allocation possible this cycle.
REQ-011 acq_addr  output  ADDRW  index granted when acq_valid and acq_ready are both high.
REQ-012 rd_addr  input  ADDRW  read index.
REQ-013 rd_data  output  DATAW  payload at rd_addr.
REQ-014 rel_valid  input  NUM_REL  per-port release strobe.
REQ-015 rel_addr  input  NUM_REL*ADDRW  per-port release index; port i occupies bits [i*ADDRW +: ADDRW].
REQ-016 count  output  CNTW  number of allocated slots.
REQ-017 empty  output  1  count == 0.
REQ-018 full  output  1  count == SIZE.
REQ-019 err_rel  output  1  sticky flag: a release targeted a free slot.

Function
REQ-020 SHALL keep a SIZE-bit free mask; bit set = slot free.
REQ-021 SHALL define the acquire fire condition as acq_fire = acq_valid & acq_ready, with acq_ready = ~full.
REQ-022 SHALL register acq_addr as the lowest-index free slot, computed from the next-state free mask (after this cycle's acquire and releases apply).
REQ-023 On acq_fire, SHALL write acq_data to acq_addr and clear the corresponding free bit; the slot shows as used from the next cycle.
REQ-024 SHALL process all NUM_REL releases in the same cycle; each valid release sets its free bit, taking effect next cycle.
REQ-025 A slot released in cycle N SHALL be grantable via acq_addr in cycle N+1, including when full was high in cycle N.
REQ-026 Duplicate release addresses on multiple ports in one cycle SHALL free the slot once, with count decremented once.
REQ-027 A release of an already-free slot SHALL leave that slot's state and count unchanged, and SHALL set err_rel until reset.
REQ-028 When a release and acq_fire occur in the same cycle, both SHALL apply.
REQ-029 count SHALL be registered, and SHALL update by +acq_fire minus the number of distinct slots newly freed; count SHALL never wrap.
REQ-030 empty and full SHALL be registered, derived from the next-state count, and consistent with count every cycle.
REQ-031 OUT_REG=0: rd_data SHALL be an asynchronous read; a same-cycle write to rd_addr SHALL return the old data, with the new data visible the next cycle.
REQ-032 OUT_REG=1: rd_data SHALL reflect rd_addr sampled the previous cycle; if that cycle wrote the same address, rd_data SHALL return the old data.
REQ-033 Storage SHALL be a dual-port RAM with one write port and one read port; reading a free slot SHALL return stale data without error.
REQ-034 acq_valid while full SHALL be ignored, with no write and no state change.

Reset
REQ-035 On reset, all slots SHALL be free, acq_addr = 0, count = 0, empty = 1, full = 0, err_rel = 0, and acq_ready = 1.
REQ-036 With OUT_REG=1, the rd_data register SHALL reset to 0; RAM contents are not reset.
REQ-037 Reset asserted mid-operation SHALL discard all allocations in the same edge; any acq_fire or release in the reset cycle SHALL be ignored.

Verification
REQ-038 Fill (SIZE=4, NUM_REL=2): 4 consecutive acq_fire with data A0..A3 -> acq_addr 0,1,2,3; then count=4, full=1, acq_ready=0, empty=0.
REQ-039 Dual release from full: release 1 and 3 in one cycle -> next cycle count=2, acq_addr=1; next acq_fire gets 1, then acq_addr=3.
REQ-040 Simultaneous events: with slots 0,1 used, acq_fire plus release 0 in the same cycle -> count stays 2, and next acq_addr = 0.
REQ-041 Error path: release of free slot 2 plus duplicate release of used slot 0 on both ports -> count decrements by 1, err_rel=1 and stays high.
REQ-042 Read latency: write D to slot 0 and read slot 0 in the same cycle -> OUT_REG=0 returns D the next cycle; OUT_REG=1 returns old data then D one cycle later.
REQ-043 Reset mid-run: with count=3, assert reset along with acq_valid -> next cycle count=0, empty=1, acq_addr=0, err_rel=0.
